// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared state encoding, point-size limits and legality check for fft_frame_ctrl
package fft_ctrl_pkg;

    localparam int MIN_POINT_DEF = 16;
    localparam int MAX_POINT_DEF = 1024;

    typedef logic [1:0] state_t;

    localparam state_t ST_RECONFIG = 2'd0;
    localparam state_t ST_IDLE     = 2'd1;
    localparam state_t ST_LOAD     = 2'd2;

    // A point size is usable only if it is a power of two inside the core's range.
    function automatic logic point_legal(input logic [10:0] point, input int min_p, input int max_p);
        return (int'(point) >= min_p) && (int'(point) <= max_p) &&
               ((point & (point - 11'd1)) == 11'd0);
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// rtl/fft_beat_counter.sv - 11-bit frame beat counter that wraps after the N-1 beat
module fft_beat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    input  logic [10:0] point,
    output logic [10:0] count,
    output logic        last
);

    assign last = (count == point - 11'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? 11'd0 : count + 11'd1;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - FFT frame sequencer; FFT_TLAST_CHECK_EN enables input tlast checking
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DWIDTH       = 32,
    parameter int MAX_POINT    = MAX_POINT_DEF,
    parameter int MIN_POINT    = MIN_POINT_DEF,
    parameter int MAX_INFLIGHT = 2,
    parameter int RST_CYC      = 4,
    parameter int CWIDTH       = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [10:0]       cfg_point,
    input  logic              cfg_inverse,
    input  logic              cfg_abort,
    input  logic              cfg_clear_err,
    input  logic [DWIDTH-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DWIDTH-1:0] c_s_axis_tdata,
    output logic              c_s_axis_tvalid,
    output logic              c_s_axis_tlast,
    input  logic              c_s_axis_tready,
    input  logic              c_m_axis_tvalid,
    input  logic              c_m_axis_tready,
    output logic              m_axis_tlast,
    output logic              core_reset,
    output logic [10:0]       core_point,
    output logic              core_inverse,
    output logic              busy,
    output logic              err_cfg,
    output logic              err_early,
    output logic              err_late,
    output logic [CWIDTH-1:0] frames_in,
    output logic [CWIDTH-1:0] frames_out
);

    localparam logic [7:0]        RST_LAST     = 8'(RST_CYC - 1);
    localparam logic [1:0]        INFLIGHT_MAX = 2'(MAX_INFLIGHT);
    localparam logic [CWIDTH-1:0] CNT_ONE      = 1;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  rst_cnt;
    logic [1:0]  inflight;
    logic [10:0] in_cnt;
    logic [10:0] out_cnt;
    logic        in_last;
    logic        out_last;
    logic        load_en;
    logic        in_hs;
    logic        in_done;
    logic        out_hs;
    logic        out_done;
    logic        cfg_changed;
    logic        cfg_ok;
    logic        cfg_err_evt;

    // Abort gates the input in the same cycle so no beat of the discarded frame reaches the core.
    assign load_en         = (state == ST_LOAD) && !cfg_abort;
    assign s_axis_tready   = load_en && c_s_axis_tready;
    assign c_s_axis_tvalid = load_en && s_axis_tvalid;
    assign c_s_axis_tdata  = s_axis_tdata;
    assign c_s_axis_tlast  = load_en && in_last;

    assign in_hs    = s_axis_tvalid && s_axis_tready;
    assign in_done  = in_hs && in_last;
    assign out_hs   = (state != ST_RECONFIG) && c_m_axis_tvalid && c_m_axis_tready;
    assign out_done = out_hs && out_last;

    assign m_axis_tlast = c_m_axis_tvalid && out_last;
    assign core_reset   = (state == ST_RECONFIG);
    assign busy         = (state != ST_IDLE) || (inflight != 2'd0);
    assign cfg_changed  = (cfg_point != core_point) || (cfg_inverse != core_inverse);
    assign cfg_ok       = point_legal(core_point, MIN_POINT, MAX_POINT);

    fft_beat_counter u_in_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (core_reset || cfg_abort),
        .inc   (in_hs),
        .point (core_point),
        .count (in_cnt),
        .last  (in_last)
    );

    fft_beat_counter u_out_cnt (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (core_reset),
        .inc   (out_hs),
        .point (core_point),
        .count (out_cnt),
        .last  (out_last)
    );

    always_comb begin
        state_nxt   = state;
        cfg_err_evt = 1'b0;
        case (state)
            ST_RECONFIG: if (rst_cnt == RST_LAST) state_nxt = ST_IDLE;
            ST_IDLE: begin
                // A pending config change waits for the old frames to drain before resetting the core.
                if (cfg_changed) begin
                    if (inflight == 2'd0) state_nxt = ST_RECONFIG;
                end else if (!cfg_ok) begin
                    cfg_err_evt = 1'b1;
                end else if (inflight < INFLIGHT_MAX) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: if (in_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_RECONFIG;
        endcase
        if (cfg_abort) state_nxt = ST_RECONFIG;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_RECONFIG;
            rst_cnt      <= '0;
            inflight     <= '0;
            core_point   <= '0;
            core_inverse <= 1'b0;
            frames_in    <= '0;
            frames_out   <= '0;
            err_cfg      <= 1'b0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= (core_reset && !cfg_abort) ? rst_cnt + 8'd1 : 8'd0;
            if (core_reset) begin
                core_point   <= cfg_point;
                core_inverse <= cfg_inverse;
                inflight     <= '0;
            end else if (in_done && !out_done) begin
                inflight <= inflight + 2'd1;
            end else if (out_done && !in_done) begin
                inflight <= inflight - 2'd1;
            end
            if (in_done)  frames_in  <= frames_in + CNT_ONE;
            if (out_done) frames_out <= frames_out + CNT_ONE;
            if (cfg_err_evt)        err_cfg <= 1'b1;
            else if (cfg_clear_err) err_cfg <= 1'b0;
        end
    end

`ifdef FFT_TLAST_CHECK_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_early <= 1'b0;
            err_late  <= 1'b0;
        end else begin
            if (in_hs && !in_last && s_axis_tlast) err_early <= 1'b1;
            else if (cfg_clear_err)                err_early <= 1'b0;
            if (in_hs && in_last && !s_axis_tlast) err_late <= 1'b1;
            else if (cfg_clear_err)                err_late <= 1'b0;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign err_early    = 1'b0;
    assign err_late     = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - self-checking bench for fft_frame_ctrl with a frame-level reference model
module tb_fft_frame_ctrl;

    localparam int RST_CYC      = 4;
    localparam int MAX_INFLIGHT = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [10:0] cfg_point = 11'd64;
    logic        cfg_inverse = 1'b0;
    logic        cfg_abort = 1'b0;
    logic        cfg_clear_err = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [31:0] c_s_axis_tdata;
    logic        c_s_axis_tvalid;
    logic        c_s_axis_tlast;
    logic        c_s_axis_tready = 1'b1;
    logic        c_m_axis_tvalid = 1'b0;
    logic        c_m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        core_reset;
    logic [10:0] core_point;
    logic        core_inverse;
    logic        busy;
    logic        err_cfg;
    logic        err_early;
    logic        err_late;
    logic [15:0] frames_in;
    logic [15:0] frames_out;

    fft_frame_ctrl #(
        .DWIDTH(32), .MAX_POINT(1024), .MIN_POINT(16),
        .MAX_INFLIGHT(MAX_INFLIGHT), .RST_CYC(RST_CYC), .CWIDTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_point(cfg_point), .cfg_inverse(cfg_inverse),
        .cfg_abort(cfg_abort), .cfg_clear_err(cfg_clear_err),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast(c_s_axis_tlast), .c_s_axis_tready(c_s_axis_tready),
        .c_m_axis_tvalid(c_m_axis_tvalid), .c_m_axis_tready(c_m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .core_reset(core_reset),
        .core_point(core_point), .core_inverse(core_inverse), .busy(busy),
        .err_cfg(err_cfg), .err_early(err_early), .err_late(err_late),
        .frames_in(frames_in), .frames_out(frames_out)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: frame bookkeeping from handshakes, plus a toy core that
    // makes N output beats available for every accepted input frame.
    int          m_n = 0, m_in = 0, m_out = 0, m_inflight = 0, m_fin = 0, m_fout = 0, pend = 0;
    int          dut_in_beats = 0, dut_out_beats = 0, last_in_len = 0, last_out_len = 0;
    int          tlast_pos = 0;
    logic [31:0] src_data = 32'h1234_5678;
    bit          mon_en = 0, src_en = 0, sink_en = 0, sink_toggle = 0;
    bit          hs_in, hs_out;

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_n = 0; m_in = 0; m_out = 0; m_inflight = 0; m_fin = 0; m_fout = 0; pend = 0;
            dut_in_beats = 0; dut_out_beats = 0;
        end else if (mon_en) begin
            hs_in  = s_axis_tvalid && s_axis_tready;
            hs_out = c_m_axis_tvalid && c_m_axis_tready && !core_reset;
            chk("pass_hs", int'(c_s_axis_tvalid && c_s_axis_tready), int'(hs_in));
            if (hs_in) chk("pass_data", int'(c_s_axis_tdata), int'(s_axis_tdata));
            if (s_axis_tready) chk("c_s_tlast", int'(c_s_axis_tlast), int'(m_in == m_n - 1));
            if (core_reset || m_inflight >= MAX_INFLIGHT) chk("in_gate", int'(s_axis_tready), 0);
            if (!core_reset) begin
                chk("m_tlast", int'(m_axis_tlast), int'(c_m_axis_tvalid && (m_out == m_n - 1)));
                chk("core_point", int'(core_point), m_n);
            end
            chk("frames_in", int'(frames_in), m_fin % 65536);
            chk("frames_out", int'(frames_out), m_fout % 65536);

            if (hs_in) begin
                src_data = $urandom;
                dut_in_beats++;
                if (c_s_axis_tlast) begin last_in_len = dut_in_beats; dut_in_beats = 0; end
                if (m_in == m_n - 1) begin
                    m_in = 0; m_fin++; m_inflight++; pend += m_n;
                end else m_in++;
            end
            if (hs_out) begin
                pend--;
                dut_out_beats++;
                if (m_axis_tlast) begin last_out_len = dut_out_beats; dut_out_beats = 0; end
                if (m_out == m_n - 1) begin
                    m_out = 0; m_fout++; m_inflight--;
                end else m_out++;
            end
            if (core_reset || cfg_abort) begin
                m_in = 0; m_out = 0; m_inflight = 0; pend = 0; dut_in_beats = 0; dut_out_beats = 0;
            end
            if (core_reset) m_n = int'(cfg_point);
        end
    end

    initial forever begin
        @(posedge aclk);
        #1;
        s_axis_tvalid   = src_en;
        s_axis_tdata    = src_data;
        s_axis_tlast    = (m_in + 1 == ((tlast_pos != 0) ? tlast_pos : m_n));
        c_s_axis_tready = 1'b1;
        c_m_axis_tvalid = sink_en && (pend > 0);
        c_m_axis_tready = sink_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_fin(input int target, input int bound);
        int b = 0;
        while (int'(frames_in) != target && b < bound) begin step(); b++; end
    endtask

    task automatic wait_fout(input int target, input int bound);
        int b = 0;
        while (int'(frames_out) != target && b < bound) begin step(); b++; end
    endtask

    task automatic wait_point(input int target, input int bound);
        int b = 0;
        while (int'(core_point) != target && b < bound) begin step(); b++; end
    endtask

    task automatic wait_min_beats(input int target, input int bound);
        int b = 0;
        while (m_in < target && b < bound) begin step(); b++; end
    endtask

    task automatic pulse_clear();
        cfg_clear_err = 1'b1;
        @(posedge aclk);
        #1 cfg_clear_err = 1'b0;
        #1;
    endtask

    initial begin
        int e, rc, f;
        src_en = 1;
        repeat (3) @(posedge aclk);
        #2;
        chk("rst_s_tready", int'(s_axis_tready), 0);
        chk("rst_c_s_tvalid", int'(c_s_axis_tvalid), 0);
        chk("rst_core_reset", int'(core_reset), 1);
        chk("rst_core_point", int'(core_point), 0);
        chk("rst_core_inverse", int'(core_inverse), 0);
        chk("rst_flags", int'({err_cfg, err_early, err_late}), 0);
        chk("rst_frames", int'(frames_in) + int'(frames_out), 0);
        chk("rst_busy", int'(busy), 1);
        aresetn = 1'b1;
        mon_en  = 1;

        e = 0;
        while (!s_axis_tready && e < 40) begin step(); e++; end
        chk("first_accept_edge", e + 1, RST_CYC + 2);
        wait_fin(1, 2000);
        chk("t1_frames_in", int'(frames_in), 1);
        chk("t1_frame_len", last_in_len, 64);

        wait_fin(2, 2000);
        rc = 0;
        repeat (30) begin step(); if (s_axis_tready) rc++; end
        chk("stall_ready_cycles", rc, 0);
        chk("stall_frames_in", int'(frames_in), 2);
        chk("stall_busy", int'(busy), 1);

        sink_en = 1;
        sink_toggle = 1;
        wait_fout(1, 1000);
        chk("t2_frames_out", int'(frames_out), 1);
        chk("t2_out_len", last_out_len, 64);
        e = 0;
        while (!s_axis_tready && e < 5) begin step(); e++; end
        chk("t2_ready_resume", int'(s_axis_tready), 1);

        cfg_point = 11'd256;
        wait_point(256, 3000);
        f = int'(frames_in);
        wait_fin(f + 1, 3000);
        chk("t4_len_256", last_in_len, 256);
        wait_min_beats(100, 500);
        cfg_point = 11'd512;
        e = 0;
        while (!core_reset && e < 4000) begin step(); e++; end
        chk("t4_reset_seen", int'(core_reset), 1);
        chk("t4_pre_len", last_in_len, 256);
        rc = 0;
        while (core_reset && rc < 20) begin step(); rc++; end
        chk("t4_reset_pulse", rc, RST_CYC);
        f = int'(frames_in);
        wait_fin(f + 1, 3000);
        chk("t4_len_512", last_in_len, 512);
        chk("t4_core_point", int'(core_point), 512);

        cfg_point = 11'd100;
        e = 0;
        while (!err_cfg && e < 5000) begin step(); e++; end
        chk("t5_err_cfg_set", int'(err_cfg), 1);
        chk("t5_core_point", int'(core_point), 100);
        rc = 0;
        repeat (10) begin step(); if (s_axis_tready) rc++; end
        chk("t5_ready_cycles", rc, 0);
        chk("t5_busy", int'(busy), 0);
        pulse_clear();
        chk("t5_set_wins", int'(err_cfg), 1);
        cfg_point = 11'd128;
        pulse_clear();
        chk("t5_err_cfg_clr", int'(err_cfg), 0);
        f = int'(frames_in);
        wait_fin(f + 1, 2000);
        chk("t5_len_128", last_in_len, 128);
        chk("t5_err_cfg_stays", int'(err_cfg), 0);

        step();
        wait_min_beats(20, 500);
        f = int'(frames_in);
        cfg_abort = 1'b1;
        #1;
        chk("t6_abort_gate", int'(s_axis_tready), 0);
        @(posedge aclk);
        #1 cfg_abort = 1'b0;
        #1;
        chk("t6_abort_reset", int'(core_reset), 1);
        chk("t6_frames_kept", int'(frames_in), f);
        wait_fin(f + 1, 2000);
        chk("t6_len_after_abort", last_in_len, 128);

        cfg_point = 11'd16;
        cfg_inverse = 1'b1;
        wait_point(16, 3000);
        chk("t7_core_inverse", int'(core_inverse), 1);
        pulse_clear();
        tlast_pos = 10;
        f = int'(frames_in);
        wait_fin(f + 2, 1000);
`ifdef FFT_TLAST_CHECK_EN
        chk("t7_err_early", int'(err_early), 1);
        chk("t7_err_late", int'(err_late), 1);
`else
        chk("t7_err_early", int'(err_early), 0);
        chk("t7_err_late", int'(err_late), 0);
`endif
        chk("t7_len_16", last_in_len, 16);
        tlast_pos = 0;
        pulse_clear();
        chk("t7_errs_cleared", int'({err_early, err_late}), 0);
        f = int'(frames_in);
        wait_fin(f + 2, 1000);
        chk("t7_errs_clean", int'({err_early, err_late}), 0);
        chk("t7_frames_advance", int'(frames_in), f + 2);

        src_en = 0;
        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
